prga_fifo_wr_buffer: RTL and testbench
======================================

# prga_fifo_wr_buffer

Write-side timing buffer for `prga_fifo`: the producer-facing counterpart of the read-side lookahead buffer. It sits between an upstream writer (`full`/`wr`/`din`) and a FIFO's write port. It presents the same write protocol upstream, but with `full`, `wr_o` and `din_o` all driven directly from flops, which breaks the combinational `full` path from the FIFO back into the producer. A two-entry skid store absorbs the one write that can arrive after the downstream FIFO fills.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each data word.

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `full`  output  1  upstream back-pressure; registered; high means a write this cycle is not accepted.
- `wr`  input  1  upstream write strobe; accepted only when `wr && !full`.
- `din`  input  DATA_WIDTH  upstream write data, sampled on an accepted write.
- `full_i`  input  1  downstream FIFO full.
- `wr_o`  output  1  downstream write strobe; registered; high whenever the head entry is valid.
- `din_o`  output  DATA_WIDTH  downstream write data; registered; equals the head entry.

## Operation
- Storage: a head register (drives `din_o`), a skid register, and an occupancy count `cnt` in {0,1,2}.
- Flags: `wr_o = (cnt != 0)`; `full = (cnt == 2)`. Both are held in dedicated flops updated with `cnt`, with no combinational path from any input.
- Accept: `acc = wr && !full`. Drain: `drn = wr_o && !full_i`.
- Order is strictly FIFO; every accepted word is presented on `din_o` exactly once, with no duplication or loss.
- Next-state rules by `cnt`:
  - cnt=0, acc: head<=din, cnt->1.
  - cnt=0, no acc: hold.
  - cnt=1, acc & drn: head<=din, cnt stays 1.
  - cnt=1, acc & !drn: skid<=din, cnt->2.
  - cnt=1, !acc & drn: cnt->0.
  - cnt=1, idle: hold.
  - cnt=2, drn: head<=skid, cnt->1. `full` is high, so acc cannot occur.
  - cnt=2, !drn: hold.
- A `wr` asserted while `full`=1 is a protocol violation. It is ignored: no state change, and no data is overwritten.
- `din_o` is don't-care while `wr_o`=0 but must not change unless the head register is loaded.
- Reset (asynchronous, `rst_n`=0): cnt=0, `full`=0, `wr_o`=0, `din_o`=0, skid=0.
  - Reset may assert mid-operation. All buffered words are discarded and the outputs take their reset values immediately, without waiting for a clock edge.
  - Reset release is synchronous to `clk`; the first accept is possible on the first edge with `rst_n`=1.

## Timing
- Latency: a word accepted at edge N is driven on `wr_o`/`din_o` from edge N (visible in cycle N+1) when cnt was 0 or was 1 with a simultaneous drain. No bypass path exists; the minimum latency is one cycle.
- Throughput: one word per cycle sustained while `full_i`=0; `full` never asserts in that case.
- `full_i` rising: at most one further word is accepted (it goes to skid). `full` rises one cycle after `full_i` blocks a pending head.
- `full_i` falling with cnt=2: head drains that cycle. `full` deasserts the next cycle, and the skid word appears on `din_o` the next cycle.
- Worst case: `full_i` toggling every cycle still yields no loss and no duplication.

## Test plan
- Reset then stream: with `full_i`=0, write 0x01..0x08 on consecutive cycles. Expect `wr_o` high for 8 consecutive cycles starting one cycle after the first write, `din_o`=0x01..0x08 in order, and `full` always 0.
- Skid fill: with cnt=1 (head 0xA0), raise `full_i` and write 0xA1. Expect `full`=1 the next cycle and `din_o` held at 0xA0. Drop `full_i`: expect 0xA0 then 0xA1 drained, and `full` back to 0 after the first drain.
- Violation: at cnt=2, assert `wr` with 0xFF for 3 cycles. Expect cnt unchanged and the later drain sequence to contain no 0xFF.
- Random back-pressure: 1000 random words with random `wr` and `full_i` (50%). The scoreboard must match the downstream sequence to the accepted sequence exactly, with `full` never high while cnt<2.
- Async reset mid-stream: at cnt=2, pulse `rst_n` low between clock edges. Expect `wr_o`=0, `full`=0 and `din_o`=0 before the next edge, and the first post-reset word 0x55 to appear alone.
- Chained with `prga_fifo` (LOOKAHEAD=0, depth filled to full): fill until the FIFO is full, then drain via `rd`. Every word must be read out once, in order, with the FIFO never written while its `full` is high.

Source files
------------

// File: rtl/prga_fifo_wr_buffer_if.sv
// Write-side handshake bundle between an upstream producer, the write buffer and a FIFO write port.
// The slave modport is the buffer's view of the bundle; the master modport is the surrounding environment's view.
interface prga_fifo_wr_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  full;
    logic                  wr;
    logic [DATA_WIDTH-1:0] din;
    logic                  full_i;
    logic                  wr_o;
    logic [DATA_WIDTH-1:0] din_o;

    modport slave (
        output full,
        input  wr,
        input  din,
        input  full_i,
        output wr_o,
        output din_o
    );

    modport master (
        input  full,
        output wr,
        output din,
        output full_i,
        input  wr_o,
        input  din_o
    );
endinterface

// File: rtl/prga_fifo_wr_buffer.sv
// Registered write-side buffer: head + skid entries so full/wr_o/din_o all come straight from flops.
// A word accepted into an empty buffer appears on din_o one cycle later; the skid entry catches the one late write.
module prga_fifo_wr_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    prga_fifo_wr_buffer_if.slave     bus
);

    typedef enum logic [1:0] {
        CNT0 = 2'd0,
        CNT1 = 2'd1,
        CNT2 = 2'd2
    } cnt_e;

    cnt_e                  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  full_q, full_d;
    logic                  wrO_q, wrO_d;

    logic                  acc;
    logic                  drn;

    assign acc = bus.wr && !full_q;
    assign drn = wrO_q && !bus.full_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT0;
            head_q <= '0;
            skid_q <= '0;
            full_q <= 1'b0;
            wrO_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            skid_q <= skid_d;
            full_q <= full_d;
            wrO_q  <= wrO_d;
        end
    end

    // The flags are derived from the next occupancy so they stay in lockstep with cnt_q.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        skid_d = skid_q;
        unique case (cnt_q)
            CNT0: begin
                if (acc) begin
                    head_d = bus.din;
                    cnt_d  = CNT1;
                end
            end
            CNT1: begin
                if (acc && drn) begin
                    head_d = bus.din;
                end else if (acc) begin
                    skid_d = bus.din;
                    cnt_d  = CNT2;
                end else if (drn) begin
                    cnt_d  = CNT0;
                end
            end
            CNT2: begin
                if (drn) begin
                    head_d = skid_q;
                    cnt_d  = CNT1;
                end
            end
            default: begin
                cnt_d = CNT0;
            end
        endcase
        full_d = (cnt_d == CNT2);
        wrO_d  = (cnt_d != CNT0);
    end

    assign bus.full  = full_q;
    assign bus.wr_o  = wrO_q;
    assign bus.din_o = head_q;

endmodule

// File: tb/tb_prga_fifo_wr_buffer.sv
// Directed bench for prga_fifo_wr_buffer: a queue model of the buffered words predicts full/wr_o/din_o every cycle.
// A small behavioural FIFO stands in for prga_fifo in the chained scenario.
module tb_prga_fifo_wr_buffer;

    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [DW-1:0] mq[$];

    prga_fifo_wr_buffer_if #(.DATA_WIDTH(DW)) bus ();

    prga_fifo_wr_buffer #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW+1:0] expState();
        logic [DW-1:0] front;
        front = (mq.size() != 0) ? mq[0] : '0;
        return {mq.size() == 2, mq.size() != 0, front};
    endfunction

    function automatic logic [DW+1:0] obsState();
        return {bus.full, bus.wr_o, bus.wr_o ? bus.din_o : {DW{1'b0}}};
    endfunction

    // Advance the model with the inputs currently applied, then step past the next rising edge.
    task automatic modelTick();
        bit acc;
        bit drn;
        acc = bus.wr && (mq.size() < 2);
        drn = (mq.size() > 0) && !bus.full_i;
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(bus.din);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic fi);
        bus.wr     = w;
        bus.din    = d;
        bus.full_i = fi;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.full, bus.wr_o, bus.din_o} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL reset full/wr_o/din_o actual=%b/%b/%h required=0/0/00", bus.full, bus.wr_o, bus.din_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) applyStimulus(1'b1, 8'(i), 1'b0);
            else        applyStimulus(1'b0, 8'h00, 1'b0);
            modelTick();
            checks++;
            if (obsState() !== expState()) begin
                failures++;
                $display("[TB] FAIL stream[%0d] actual=%h required=%h", i, obsState(), expState());
            end
        end
    endtask

    task automatic test_skid();
        logic [DW-1:0] vecD[5]  = '{8'hA0, 8'hA1, 8'h00, 8'h00, 8'h00};
        logic          vecW[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          vecF[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecW[i], vecD[i], vecF[i]);
            modelTick();
            checks++;
            if (obsState() !== expState()) begin
                failures++;
                $display("[TB] FAIL skid[%0d] actual=%h required=%h", i, obsState(), expState());
            end
        end
    endtask

    task automatic test_violation();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      applyStimulus(1'b1, 8'hB0, 1'b1);
            else if (i == 1) applyStimulus(1'b1, 8'hB1, 1'b1);
            else if (i < 5)  applyStimulus(1'b1, 8'hFF, 1'b1);
            else             applyStimulus(1'b0, 8'h00, 1'b0);
            modelTick();
            checks++;
            if (obsState() !== expState()) begin
                failures++;
                $display("[TB] FAIL violation[%0d] actual=%h required=%h", i, obsState(), expState());
            end
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            modelTick();
            checks++;
            if (obsState() !== expState()) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random[%0d] actual=%h required=%h", i, obsState(), expState());
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) modelTick();
        checks++;
        if (obsState() !== expState()) begin
            failures++;
            $display("[TB] FAIL random_drain actual=%h required=%h", obsState(), expState());
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 8'hD0, 1'b1);
        modelTick();
        applyStimulus(1'b1, 8'hD1, 1'b1);
        modelTick();
        checks++;
        if (obsState() !== expState()) begin
            failures++;
            $display("[TB] FAIL async_prefill actual=%h required=%h", obsState(), expState());
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.full, bus.wr_o, bus.din_o} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL async_reset full/wr_o/din_o actual=%b/%b/%h required=0/0/00", bus.full, bus.wr_o, bus.din_o);
        end
        #1;
        rst_n = 1'b1;
        mq.delete();
        applyStimulus(1'b1, 8'h55, 1'b0);
        modelTick();
        checks++;
        if (obsState() !== {1'b0, 1'b1, 8'h55}) begin
            failures++;
            $display("[TB] FAIL async_first actual=%h required=%h", obsState(), {1'b0, 1'b1, 8'h55});
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        modelTick();
        checks++;
        if (obsState() !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL async_alone actual=%h required=%h", obsState(), {1'b0, 1'b0, 8'h00});
        end
    endtask

    // A depth-4 behavioural FIFO with a combinational full flag drives full_i.
    task automatic test_chained();
        logic [DW-1:0] fifoQ[$];
        logic [DW-1:0] readQ[$];
        logic [DW-1:0] nextWord;
        bit            rd;
        int            accepted;
        nextWord = 8'hC0;
        accepted = 0;
        for (int i = 0; i < 24; i++) begin
            rd = (i >= 12);
            bus.full_i = (fifoQ.size() == 4);
            bus.wr     = (i < 12);
            bus.din    = nextWord;
            if (bus.wr && mq.size() < 2) begin
                nextWord++;
                accepted++;
            end
            if (rd && fifoQ.size() > 0) readQ.push_back(fifoQ.pop_front());
            if (bus.wr_o && !bus.full_i) fifoQ.push_back(bus.din_o);
            modelTick();
            checks++;
            if (obsState() !== expState()) begin
                failures++;
                $display("[TB] FAIL chained[%0d] actual=%h required=%h", i, obsState(), expState());
            end
        end
        checks++;
        if (readQ.size() != 6 || accepted != 6) begin
            failures++;
            $display("[TB] FAIL chained_count read=%0d accepted=%0d required=6", readQ.size(), accepted);
        end
        for (int i = 0; i < readQ.size(); i++) begin
            checks++;
            if (readQ[i] !== 8'(8'hC0 + i)) begin
                failures++;
                $display("[TB] FAIL chained_order[%0d] actual=%h required=%h", i, readQ[i], 8'(8'hC0 + i));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        test_reset();
        test_stream();
        test_skid();
        test_violation();
        test_random();
        test_async_reset();
        test_chained();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
